// File: rtl/blink_seq.sv
// LED blink sequencer: accepts (count, on, off) commands and plays count on/off blinks in prescaled ticks.
// Optional abort_i input is enabled with `define BLINK_SEQ_ABORT_EN.
module blink_seq #(
  parameter int PRESCALE = 125000,
  parameter int TWIDTH   = 8,
  parameter int NWIDTH   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [NWIDTH-1:0] cmd_count_i,
  input  logic [TWIDTH-1:0] cmd_on_i,
  input  logic [TWIDTH-1:0] cmd_off_i,
`ifdef BLINK_SEQ_ABORT_EN
  input  logic              abort_i,
`endif
  output logic              led_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int PW  = $clog2(PRESCALE);
  localparam int TW1 = TWIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [TW1-1:0]    tick_q, tick_d;
  logic [NWIDTH-1:0] count_q, count_d;
  logic [TWIDTH-1:0] on_q, on_d;
  logic [TWIDTH-1:0] off_q, off_d;
  logic              led_q, led_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;

  logic              abort;
  logic              presc_wrap;
  logic [TW1-1:0]    tick_inc;
  logic [NWIDTH-1:0] count_dec;

`ifdef BLINK_SEQ_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  assign presc_wrap = (presc_q == PW'(PRESCALE - 1));
  assign tick_inc   = tick_q + TW1'(1);
  assign count_dec  = count_q - NWIDTH'(1);

  // Zero-length phases are stored as one tick, so the phase compare never sees 0.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tick_d  = tick_q;
    count_d = count_q;
    on_d    = on_q;
    off_d   = off_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i && ready_q) begin
          on_d    = (cmd_on_i  == '0) ? TWIDTH'(1) : cmd_on_i;
          off_d   = (cmd_off_i == '0) ? TWIDTH'(1) : cmd_off_i;
          count_d = cmd_count_i;
          presc_d = '0;
          tick_d  = '0;
          if (cmd_count_i != '0) begin
            state_d = ON;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ON: begin
        if (abort) begin
          state_d = IDLE;
          presc_d = '0;
          tick_d  = '0;
          count_d = '0;
        end else begin
          presc_d = presc_wrap ? '0 : presc_q + PW'(1);
          if (presc_wrap) begin
            if (tick_inc == {1'b0, on_q}) begin
              tick_d  = '0;
              state_d = OFF;
            end else begin
              tick_d = tick_inc;
            end
          end
        end
      end
      OFF: begin
        if (abort) begin
          state_d = IDLE;
          presc_d = '0;
          tick_d  = '0;
          count_d = '0;
        end else begin
          presc_d = presc_wrap ? '0 : presc_q + PW'(1);
          if (presc_wrap) begin
            if (tick_inc == {1'b0, off_q}) begin
              tick_d  = '0;
              count_d = count_dec;
              if (count_dec != '0) begin
                state_d = ON;
              end else begin
                state_d = IDLE;
                presc_d = '0;
                done_d  = 1'b1;
              end
            end else begin
              tick_d = tick_inc;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        presc_d = '0;
        tick_d  = '0;
        count_d = '0;
      end
    endcase

    led_d   = (state_d == ON);
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      presc_q <= '0;
      tick_q  <= '0;
      count_q <= '0;
      on_q    <= '0;
      off_q   <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      count_q <= count_d;
      on_q    <= on_d;
      off_q   <= off_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign led_o       = led_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_blink_seq.sv
// Self-checking bench for blink_seq (PRESCALE=4): per-cycle expected {led,busy,done,ready} traces in a scoreboard queue.
// Abort scenario is built only when BLINK_SEQ_ABORT_EN is defined.
module tb_blink_seq;

  localparam int PRESCALE = 4;
  localparam int TWIDTH   = 8;
  localparam int NWIDTH   = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [NWIDTH-1:0] cmd_count_i;
  logic [TWIDTH-1:0] cmd_on_i;
  logic [TWIDTH-1:0] cmd_off_i;
`ifdef BLINK_SEQ_ABORT_EN
  logic              abort_i;
`endif
  logic              led_o;
  logic              busy_o;
  logic              done_o;

  int checks = 0;
  int errors = 0;

  // Expected {led, busy, done, ready}, one entry per cycle after an edge.
  logic [3:0] exp_q[$];
  logic [3:0] exp_v;
  logic [3:0] obs_v;

  localparam logic [3:0] S_ON   = 4'b1100;
  localparam logic [3:0] S_OFF  = 4'b0100;
  localparam logic [3:0] S_DONE = 4'b0011;
  localparam logic [3:0] S_IDLE = 4'b0001;

  blink_seq #(
    .PRESCALE(PRESCALE),
    .TWIDTH  (TWIDTH),
    .NWIDTH  (NWIDTH)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_count_i(cmd_count_i),
    .cmd_on_i   (cmd_on_i),
    .cmd_off_i  (cmd_off_i),
`ifdef BLINK_SEQ_ABORT_EN
    .abort_i    (abort_i),
`endif
    .led_o      (led_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected trace of a whole command, derived from its fields alone.
  task automatic push_cmd(input int count, input int on, input int off);
    int on_eff;
    int off_eff;
    on_eff  = (on  == 0) ? 1 : on;
    off_eff = (off == 0) ? 1 : off;
    for (int b = 0; b < count; b++) begin
      for (int c = 0; c < on_eff * PRESCALE; c++) exp_q.push_back(S_ON);
      for (int c = 0; c < off_eff * PRESCALE; c++) exp_q.push_back(S_OFF);
    end
    exp_q.push_back(S_DONE);
  endtask

  task automatic drive_cmd(input int count, input int on, input int off);
    cmd_valid_i = 1'b1;
    cmd_count_i = NWIDTH'(count);
    cmd_on_i    = TWIDTH'(on);
    cmd_off_i   = TWIDTH'(off);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    obs_v = {led_o, busy_o, done_o, cmd_ready_o};
    checks++;
    if (obs_v !== S_IDLE) begin
      errors++;
      $display("[TB] FAIL reset_hold got %b expected %b", obs_v, S_IDLE);
    end
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    obs_v = {led_o, busy_o, done_o, cmd_ready_o};
    checks++;
    if (obs_v !== S_IDLE) begin
      errors++;
      $display("[TB] FAIL reset_release got %b expected %b", obs_v, S_IDLE);
    end
  endtask

  task automatic test_basic_blink();
    int idx = 0;
    drive_cmd(2, 3, 1);
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
    push_cmd(2, 3, 1);
    exp_q.push_back(S_IDLE);
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      obs_v = {led_o, busy_o, done_o, cmd_ready_o};
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL basic_blink cycle %0d got %b expected %b", idx, obs_v, exp_v);
      end
      idx++;
      if (exp_q.size() > 0) begin
        @(posedge clk_i);
        #1;
      end
    end
  endtask

  task automatic test_zero_count();
    int idx = 0;
    drive_cmd(0, 5, 5);
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
    push_cmd(0, 5, 5);
    exp_q.push_back(S_IDLE);
    exp_q.push_back(S_IDLE);
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      obs_v = {led_o, busy_o, done_o, cmd_ready_o};
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL zero_count cycle %0d got %b expected %b", idx, obs_v, exp_v);
      end
      idx++;
      if (exp_q.size() > 0) begin
        @(posedge clk_i);
        #1;
      end
    end
  endtask

  task automatic test_zero_length();
    int idx = 0;
    drive_cmd(1, 0, 0);
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
    push_cmd(1, 0, 0);
    exp_q.push_back(S_IDLE);
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      obs_v = {led_o, busy_o, done_o, cmd_ready_o};
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL zero_length cycle %0d got %b expected %b", idx, obs_v, exp_v);
      end
      idx++;
      if (exp_q.size() > 0) begin
        @(posedge clk_i);
        #1;
      end
    end
  endtask

  // Valid stays high throughout; new fields offered mid-run must not be taken until the done cycle.
  task automatic test_back_to_back();
    int idx = 0;
    drive_cmd(1, 1, 1);
    @(posedge clk_i);
    #1;
    drive_cmd(1, 2, 1);
    push_cmd(1, 1, 1);
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      obs_v = {led_o, busy_o, done_o, cmd_ready_o};
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL b2b_first cycle %0d got %b expected %b", idx, obs_v, exp_v);
      end
      idx++;
      if (exp_q.size() > 0) begin
        @(posedge clk_i);
        #1;
      end
    end
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
    push_cmd(1, 2, 1);
    exp_q.push_back(S_IDLE);
    idx = 0;
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      obs_v = {led_o, busy_o, done_o, cmd_ready_o};
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL b2b_second cycle %0d got %b expected %b", idx, obs_v, exp_v);
      end
      idx++;
      if (exp_q.size() > 0) begin
        @(posedge clk_i);
        #1;
      end
    end
  endtask

  task automatic test_reset_mid();
    int idx = 0;
    drive_cmd(2, 3, 1);
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
    for (int c = 0; c < 5; c++) exp_q.push_back(S_ON);
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      obs_v = {led_o, busy_o, done_o, cmd_ready_o};
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL reset_mid_on cycle %0d got %b expected %b", idx, obs_v, exp_v);
      end
      idx++;
      if (exp_q.size() > 0) begin
        @(posedge clk_i);
        #1;
      end
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (led_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_async got led=%b busy=%b done=%b expected 0 0 0", led_o, busy_o, done_o);
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk_i);
      #1;
      checks++;
      if (done_o !== 1'b0 || led_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_mid_hold got led=%b done=%b expected 0 0", led_o, done_o);
      end
    end
    rst_i = 1'b0;
    for (int c = 0; c < 3; c++) exp_q.push_back(S_IDLE);
    idx = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk_i);
      #1;
      exp_v = exp_q.pop_front();
      obs_v = {led_o, busy_o, done_o, cmd_ready_o};
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL reset_mid_after cycle %0d got %b expected %b", idx, obs_v, exp_v);
      end
      idx++;
    end
  endtask

`ifdef BLINK_SEQ_ABORT_EN
  task automatic test_abort();
    int idx = 0;
    drive_cmd(3, 1, 1);
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
    for (int c = 0; c < PRESCALE; c++) exp_q.push_back(S_ON);
    exp_q.push_back(S_OFF);
    exp_q.push_back(S_OFF);
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      obs_v = {led_o, busy_o, done_o, cmd_ready_o};
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL abort_run cycle %0d got %b expected %b", idx, obs_v, exp_v);
      end
      idx++;
      if (exp_q.size() > 0) begin
        @(posedge clk_i);
        #1;
      end
    end
    abort_i = 1'b1;
    @(posedge clk_i);
    #1;
    abort_i = 1'b0;
    for (int c = 0; c < 3; c++) exp_q.push_back(S_IDLE);
    idx = 0;
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      obs_v = {led_o, busy_o, done_o, cmd_ready_o};
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL abort_idle cycle %0d got %b expected %b", idx, obs_v, exp_v);
      end
      idx++;
      if (exp_q.size() > 0) begin
        @(posedge clk_i);
        #1;
      end
    end
  endtask
`endif

  initial begin
    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_count_i = '0;
    cmd_on_i    = '0;
    cmd_off_i   = '0;
`ifdef BLINK_SEQ_ABORT_EN
    abort_i     = 1'b0;
`endif
    test_reset();
    test_basic_blink();
    test_zero_count();
    test_zero_length();
    test_back_to_back();
    test_reset_mid();
`ifdef BLINK_SEQ_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
